// File: rtl/tile_line_fetcher.sv
// Tile line fetcher: walks one tilemap row per scanline and streams one pattern row per cycle.
// Scrolling (scroll_x/scroll_y, extra wrap slot) is compiled in only when TILE_SCROLL_EN is defined.
module tile_line_fetcher #(
  parameter int TILE_W   = 16,
  parameter int TILE_H   = 16,
  parameter int PIX_BITS = 16,
  parameter int TILES_X  = 40,
  parameter int TILES_Y  = 30,
  parameter int NUM_MAPS = 4,
  parameter int ID_BITS  = 8,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         line_start,
  input  logic [9:0]                                   vcount,
  input  logic [$clog2(NUM_MAPS)-1:0]                  map_sel,
  input  logic [9:0]                                   scroll_x,
  input  logic [9:0]                                   scroll_y,
  output logic [$clog2(NUM_MAPS*TILES_X*TILES_Y)-1:0]  map_addr,
  input  logic [ID_BITS-1:0]                           map_rdata,
  output logic [ID_BITS+$clog2(TILE_H)-1:0]            pat_addr,
  input  logic [TILE_W*PIX_BITS-1:0]                   pat_rdata,
  output logic                                         tile_valid,
  output logic [$clog2(TILES_X+1)-1:0]                 tile_col,
  output logic [TILE_W*PIX_BITS-1:0]                   tile_data,
  output logic [$clog2(TILE_W)-1:0]                    fine_x,
  output logic                                         tile_done
);
  localparam int MA  = $clog2(NUM_MAPS*TILES_X*TILES_Y);
  localparam int PAW = ID_BITS + $clog2(TILE_H);
  localparam int CLW = $clog2(TILES_X+1);
  localparam int CW  = $clog2(TILES_X);
  localparam int FXW = $clog2(TILE_W);
  localparam int FYW = $clog2(TILE_H);

  logic [9:0] sx, sy;
`ifdef TILE_SCROLL_EN
  localparam int N = TILES_X + 1;
  assign sx = scroll_x;
  assign sy = scroll_y;
`else
  localparam int N = TILES_X;
  assign sx = scroll_x & 10'd0;
  assign sy = scroll_y & 10'd0;
`endif

  localparam logic [9:0]     VA_M1 = 10'(V_ACTIVE-1);
  localparam logic [9:0]     VT_M1 = 10'(V_TOTAL-1);
  localparam logic [CLW-1:0] LAST  = CLW'(N-1);
  localparam logic [CW-1:0]  COL_MAX = CW'(TILES_X-1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;

  logic           fetch_ok;
  logic [9:0]     line_l;
  int             y_i, row_i;
  logic [FYW-1:0] fy_n;
  logic [FXW-1:0] fx_n;
  logic [CW-1:0]  col0_n, col_nx;
  logic [MA-1:0]  base_n;

  logic [CLW-1:0] slot, rd_col;
  logic [CW-1:0]  col_q;
  logic [MA-1:0]  base_q;
  logic [FYW-1:0] fine_y;
  logic           iss_vld, rd_vld;

  // Lines after the last active one (other than the wrap from V_TOTAL-1) need no fetch.
  assign fetch_ok = (vcount < VA_M1) || (vcount == VT_M1);
  assign line_l   = (vcount == VT_M1) ? 10'd0 : vcount + 10'd1;

  always_comb begin
    y_i    = (int'(line_l) + int'(sy)) % (TILES_Y*TILE_H);
    row_i  = y_i / TILE_H;
    fy_n   = FYW'(y_i % TILE_H);
    fx_n   = FXW'(int'(sx) % TILE_W);
    col0_n = CW'((int'(sx) / TILE_W) % TILES_X);
    base_n = MA'(int'(map_sel)*TILES_X*TILES_Y + row_i*TILES_X);
  end

  assign col_nx    = (col_q == COL_MAX) ? '0 : col_q + CW'(1);
  assign pat_addr  = PAW'(int'(map_rdata)*TILE_H + int'(fine_y));
  assign tile_data = pat_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tile_done  <= 1'b1;
      tile_valid <= 1'b0;
      tile_col   <= '0;
      fine_x     <= '0;
      map_addr   <= '0;
      iss_vld    <= 1'b0;
      rd_vld     <= 1'b0;
      rd_col     <= '0;
      slot       <= '0;
      col_q      <= '0;
      base_q     <= '0;
      fine_y     <= '0;
    end else begin
      // Two-stage valid/slot pipeline tracks the map read then the pattern read.
      rd_vld     <= iss_vld;
      rd_col     <= slot;
      tile_valid <= rd_vld;
      if (rd_vld) tile_col <= rd_col;

      if (line_start && fetch_ok) begin
        state      <= ISSUE;
        tile_done  <= 1'b0;
        iss_vld    <= 1'b1;
        rd_vld     <= 1'b0;
        tile_valid <= 1'b0;
        slot       <= '0;
        col_q      <= col0_n;
        base_q     <= base_n;
        fine_y     <= fy_n;
        fine_x     <= fx_n;
        map_addr   <= base_n + MA'(col0_n);
      end else if (line_start && state != IDLE) begin
        state      <= IDLE;
        tile_done  <= 1'b1;
        iss_vld    <= 1'b0;
        rd_vld     <= 1'b0;
        tile_valid <= 1'b0;
      end else begin
        case (state)
          ISSUE: begin
            if (slot == LAST) begin
              state   <= DRAIN;
              iss_vld <= 1'b0;
            end else begin
              slot     <= slot + CLW'(1);
              col_q    <= col_nx;
              map_addr <= base_q + MA'(col_nx);
            end
          end
          DRAIN: begin
            if (tile_valid && tile_col == LAST) begin
              state     <= IDLE;
              tile_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
